bfloat_addsub_pipe: RTL and testbench
=====================================

# bfloat_addsub_pipe

Parametrised, pipelined floating-point adder/subtractor: the streaming successor to the single-cycle bfloat16 add/sub unit, and the accumulate stage of the bfloat MAC datapath. Exponent and mantissa widths are parameters (bfloat16 by default, IEEE half as a second configuration). It adds valid/ready flow control with full backpressure, round-to-nearest-even, special-value handling and exception flags. Fixed three-stage pipeline, one result per cycle when unstalled.

## Interface
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 7, stored fraction width (hidden bit implicit)
- W, 1+EXP_W+MAN_W, derived operand width; not overridden
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- cntl  in  1  0 = a+b, 1 = a-b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- c  out  W  result
- flags  out  3  {invalid, overflow, underflow}, qualified by out_valid

## Operation
- Transfer occurs on in_valid && in_ready (input) and on out_valid && out_ready (output).
- Subtraction is implemented by inverting b's sign before the datapath.
- Stage 1: unpack and classify (zero, normal, inf, NaN), compare magnitudes, swap so the larger operand is first, align the smaller mantissa with a right shift by the exponent difference, and keep guard, round and sticky bits. A shift of MAN_W+3 or more leaves only sticky.
- Stage 2: mantissa add or subtract by effective operation, width MAN_W+5 (carry, hidden bit, fraction, G, R, S).
- Stage 3: normalise, either a 1-bit right shift on carry or a left shift by leading-zero count. Round to nearest, ties to even. Re-normalise on rounding carry, then pack.
- Subnormal inputs (exp = 0) are treated as signed zero.
- Results below the minimum normal flush to signed zero and raise underflow.
- Exponent ≥ all-ones after rounding produces ±inf and raises overflow.
- Any NaN input produces canonical NaN: sign 0, exp all-ones, frac MSB 1 (bf16 0x7FC0), with no flag.
- inf − inf (effective) produces canonical NaN and raises invalid.
- inf ± finite produces that inf.
- Exact cancellation produces +0.
- (−0)+(−0) produces −0.

## Timing
- Latency is exactly 3 cycles from input transfer to out_valid when out_ready is held high.
- Throughput is 1 per cycle.
- The global advance enable is en = !out_valid || out_ready; in_ready = en (combinational from out_ready).
- Each stage holds a valid bit. Bubbles are not collapsed: stages shift together when en = 1.
- While out_valid = 1 and out_ready = 0, c, flags and all stage registers hold.
- c and flags must not change until the result is transferred.
- Asserting rst clears all stage valid bits, c and flags to 0.
- In-flight operands are discarded on reset; no output appears for them.
- First acceptance is on the first rising edge after rst deasserts.
- Outputs are registered at stage 3. There is no combinational path from a or b to c.

## Structure
- Package bfloat_pkg holds:
  - fp_class_e enum {ZERO, NORM, INF, NAN}
  - parametrised unpacked-operand struct typedef
  - function canon_nan(EXP_W, MAN_W)
  - flag-bit index constants
- One sub-module, bfloat_norm_round, handles stage 3: leading-zero count, normalise shift, RNE, overflow/underflow detect and pack.
- Stages 1–2 are inline.

## Test plan
- bf16: a=0x3FB9 (1.4453125), b=0x3FA2 (1.265625), cntl=0 → c=0x402E (2.71875, tie rounded to even), flags=0, out_valid exactly 3 cycles after transfer.
- Same operands, cntl=1 → c=0x3E38 (0.1796875, exact).
- Back-to-back: a=0x4000, b=0x4000 with cntl=1 → 0x0000; then a=0x7F7F, b=0x7F7F with cntl=0 → 0x7F80, overflow=1. Results appear on consecutive cycles.
- Special values:
  - +inf (0x7F80) − +inf with cntl=1 → 0x7FC0, invalid=1.
  - 0xFFC1 (NaN) + 1.0 → 0x7FC0, flags=0.
- Backpressure: stream 5 pairs while out_ready toggles 1,0,0,1,…. All 5 results arrive in order, with no loss or duplication, and c stays stable while stalled. Assert rst mid-stream: out_valid drops to 0 asynchronously and no stale result follows.
- Instance with EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000. 0x0400 (min normal) − 0x03FF-class subnormal input is treated as zero → 0x0400.

Source files
------------

// File: rtl/bfloat_pkg.sv
// Shared types and constants for the parametrised floating-point add/sub pipeline.
// Operand fields are sized for the widest supported format; narrower formats zero-extend.
package bfloat_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    localparam int MAX_EXP_W = 11;
    localparam int MAX_MAN_W = 52;

    // Unpacked operand; mant carries the hidden bit at position MAN_W.
    typedef struct packed {
        logic                 sign;
        fp_class_e            cls;
        logic [MAX_EXP_W-1:0] exp;
        logic [MAX_MAN_W:0]   mant;
    } operand_t;

    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/bfloat_norm_round.sv
// Final stage: normalise the raw mantissa sum, round to nearest even, detect
// overflow/underflow and pack the result word.
module bfloat_norm_round
    import bfloat_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic             sign,
    input  logic [EXP_W-1:0] exp,
    input  logic [MAN_W+4:0] sum,
    output logic [W-1:0]     result,
    output logic             overflow,
    output logic             underflow
);

    localparam int SW  = MAN_W + 5;
    localparam int LZW = $clog2(SW);
    localparam int EW  = EXP_W + 2;

    logic [LZW-1:0]       lz;
    logic [MAN_W+3:0]     norm;
    logic signed [EW-1:0] e_norm;
    logic signed [EW-1:0] e_fin;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     frac;
    logic                 round_up;

    always_comb begin
        lz = '0;
        for (int i = 0; i < SW - 1; i++) begin
            if (sum[i]) lz = LZW'(SW - 2 - i);
        end

        if (sum[SW-1]) begin
            norm   = {sum[SW-1:2], sum[1] | sum[0]};
            e_norm = $signed({2'b00, exp}) + EW'(1);
        end else begin
            norm   = sum[SW-2:0] << lz;
            e_norm = $signed({2'b00, exp}) - $signed({{(EW-LZW){1'b0}}, lz});
        end

        // norm = {hidden, frac, G, R, S}
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[MAN_W+3:3]} + (MAN_W+2)'(round_up);
        if (rounded[MAN_W+1]) begin
            e_fin = e_norm + EW'(1);
            frac  = rounded[MAN_W:1];
        end else begin
            e_fin = e_norm;
            frac  = rounded[MAN_W-1:0];
        end

        overflow  = 1'b0;
        underflow = 1'b0;
        if (sum == '0) begin
            result = '0;
        end else if (e_fin <= $signed(EW'(0))) begin
            result    = {sign, {(W-1){1'b0}}};
            underflow = 1'b1;
        end else if (e_fin >= $signed({2'b00, {EXP_W{1'b1}}})) begin
            result   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow = 1'b1;
        end else begin
            result = {sign, e_fin[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/bfloat_addsub_pipe.sv
// Three-stage streaming floating-point adder/subtractor with valid/ready flow
// control; stage 1 aligns, stage 2 adds, stage 3 normalises/rounds into c.
module bfloat_addsub_pipe
    import bfloat_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cntl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [2:0]   flags
);

    localparam logic [63:0]      NAN64   = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]     NAN_VAL = NAN64[W-1:0];
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     spec_val;
        logic [2:0]       spec_flags;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [MAN_W+3:0] mag_lg;
        logic [MAN_W+3:0] mag_sm;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     spec_val;
        logic [2:0]       spec_flags;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W+4:0] sum;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] c_q, c_d;
    logic [2:0]   flags_q, flags_d;
    logic         en;

    function automatic operand_t unpack(input logic [W-1:0] x);
        operand_t         u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[W-2:MAN_W];
        f = x[MAN_W-1:0];
        u = '0;
        u.sign = x[W-1];
        if (e == '0) begin
            u.cls = ZERO;
        end else if (e == EXP_MAX) begin
            u.cls = (f == '0) ? INF : NAN;
        end else begin
            u.cls  = NORM;
            u.exp  = MAX_EXP_W'(e);
            u.mant = (MAX_MAN_W+1)'({1'b1, f});
        end
        return u;
    endfunction

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Stage 1: unpack, classify, order by magnitude, align the smaller operand.
    logic [W-1:0]             b_eff;
    operand_t                 ua, ub, ul, us;
    logic                     swap;
    logic [EXP_W-1:0]         ediff;
    logic [MAN_W:0]           ms;
    logic [2*(MAN_W+3)-1:0]   shift_vec;
    logic [MAN_W+3:0]         mag_sm;
    logic                     special;
    logic [W-1:0]             spec_val;
    logic [2:0]               spec_flags;
    logic                     unused_hi;

    // Only the low EXP_W/MAN_W+1 bits of the wide operand fields carry data.
    assign unused_hi = ^{ul, us};

    always_comb begin
        b_eff = {b[W-1] ^ cntl, b[W-2:0]};
        ua    = unpack(a);
        ub    = unpack(b_eff);
        swap  = {ua.exp, ua.mant} < {ub.exp, ub.mant};
        ul    = swap ? ub : ua;
        us    = swap ? ua : ub;
        ediff = ul.exp[EXP_W-1:0] - us.exp[EXP_W-1:0];
        ms    = us.mant[MAN_W:0];

        shift_vec = {ms, 2'b00, {(MAN_W+3){1'b0}}} >> ediff;
        if (32'(ediff) >= MAN_W + 3) begin
            mag_sm = {{(MAN_W+3){1'b0}}, |ms};
        end else begin
            mag_sm = {shift_vec[2*(MAN_W+3)-1 -: (MAN_W+3)], |shift_vec[MAN_W+2:0]};
        end

        special    = 1'b1;
        spec_val   = '0;
        spec_flags = '0;
        if (ua.cls == NAN || ub.cls == NAN) begin
            spec_val = NAN_VAL;
        end else if (ua.cls == INF && ub.cls == INF) begin
            if (ua.sign != ub.sign) begin
                spec_val             = NAN_VAL;
                spec_flags[FLAG_INV] = 1'b1;
            end else begin
                spec_val = {ua.sign, EXP_MAX, {MAN_W{1'b0}}};
            end
        end else if (ua.cls == INF) begin
            spec_val = {ua.sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (ub.cls == INF) begin
            spec_val = {ub.sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (ua.cls == ZERO && ub.cls == ZERO) begin
            spec_val = {ua.sign & ub.sign, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end

        s1_d = s1_q;
        if (en) begin
            s1_d.valid      = in_valid;
            s1_d.special    = special;
            s1_d.spec_val   = spec_val;
            s1_d.spec_flags = spec_flags;
            s1_d.sign       = ul.sign;
            s1_d.eff_sub    = ua.sign ^ ub.sign;
            s1_d.exp        = ul.exp[EXP_W-1:0];
            s1_d.mag_lg     = {ul.mant[MAN_W:0], 3'b000};
            s1_d.mag_sm     = mag_sm;
        end
    end

    // Stage 2: mantissa add/subtract; mag_lg >= mag_sm so the difference is non-negative.
    always_comb begin
        s2_d = s2_q;
        if (en) begin
            s2_d.valid      = s1_q.valid;
            s2_d.special    = s1_q.special;
            s2_d.spec_val   = s1_q.spec_val;
            s2_d.spec_flags = s1_q.spec_flags;
            s2_d.sign       = s1_q.sign;
            s2_d.exp        = s1_q.exp;
            s2_d.sum        = s1_q.eff_sub ? ({1'b0, s1_q.mag_lg} - {1'b0, s1_q.mag_sm})
                                           : ({1'b0, s1_q.mag_lg} + {1'b0, s1_q.mag_sm});
        end
    end

    logic [W-1:0] nr_result;
    logic         nr_ovf;
    logic         nr_unf;

    bfloat_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign      (s2_q.sign),
        .exp       (s2_q.exp),
        .sum       (s2_q.sum),
        .result    (nr_result),
        .overflow  (nr_ovf),
        .underflow (nr_unf)
    );

    // Stage 3: output registers change only when a new result is loaded.
    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        flags_d     = flags_q;
        if (en) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) begin
                if (s2_q.special) begin
                    c_d     = s2_q.spec_val;
                    flags_d = s2_q.spec_flags;
                end else begin
                    c_d               = nr_result;
                    flags_d           = '0;
                    flags_d[FLAG_OVF] = nr_ovf;
                    flags_d[FLAG_UNF] = nr_unf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_bfloat_addsub_pipe.sv
// Directed bench for the bf16 and IEEE-half configurations of bfloat_addsub_pipe.
module tb_bfloat_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cntl, out_valid, out_ready;
    logic [15:0] a, b, c;
    logic [2:0]  flags;

    logic        h_in_valid, h_in_ready, h_cntl, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_c;
    logic [2:0]  h_flags;

    int n_cmp  = 0;
    int n_fail = 0;

    bfloat_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cntl(cntl), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flags(flags)
    );

    bfloat_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cntl(h_cntl), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .c(h_c), .flags(h_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic [15:0] exp_c, input logic [2:0] exp_f);
        int lat;
        @(negedge clk);
        a = av; b = bv; cntl = cv; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_flags"}, flags, exp_f);
        $display("txn %s a=%h b=%h cntl=%0d -> c=%h flags=%b lat=%0d", tag, av, bv, cv, c, flags, lat);
        @(posedge clk); #1;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic run_h(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] exp_c);
        int lat;
        @(negedge clk);
        h_a = av; h_b = bv; h_cntl = cv; h_in_valid = 1'b1; h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_c"}, h_c, exp_c);
        check({tag, "_flags"}, h_flags, 0);
        $display("txn %s a=%h b=%h cntl=%0d -> c=%h flags=%b lat=%0d", tag, av, bv, cv, h_c, h_flags, lat);
        @(posedge clk); #1;
    endtask

    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    logic        bp_op[5];
    logic [15:0] bp_c [5];

    initial begin
        int  sent, got, lat;
        bit  accepted, delivered;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cntl = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_cntl = 1'b0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 16'h0000);
        check("rst_flags", flags, 0);
        check("rst_h_out_valid", h_out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        run_one("add_tie",  16'h3FB9, 16'h3FA2, 1'b0, 16'h402E, 3'b000);
        run_one("sub",      16'h3FB9, 16'h3FA2, 1'b1, 16'h3E38, 3'b000);
        run_one("inf_inf",  16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100);
        run_one("nan_in",   16'hFFC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b000);
        run_one("inf_fin",  16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 3'b000);
        run_one("negzero",  16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);
        run_one("underflw", 16'h8081, 16'h0080, 1'b0, 16'h8000, 3'b001);

        // Back-to-back pair, results expected on consecutive cycles.
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; cntl = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 16'h7F7F; b = 16'h7F7F; cntl = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_cancel_c", c, 16'h0000);
        check("b2b_cancel_flags", flags, 0);
        $display("txn b2b_cancel c=%h flags=%b", c, flags);
        @(posedge clk); #1;
        check("b2b_ovf_valid", out_valid, 1);
        check("b2b_ovf_c", c, 16'h7F80);
        check("b2b_ovf_flags", flags, 3'b010);
        $display("txn b2b_ovf c=%h flags=%b", c, flags);
        @(posedge clk); #1;

        // Backpressure stream with out_ready pattern 1,0,0,1 repeating.
        bp_a[0] = 16'h3F80; bp_b[0] = 16'h3F80; bp_op[0] = 1'b0; bp_c[0] = 16'h4000;
        bp_a[1] = 16'h4000; bp_b[1] = 16'h3F80; bp_op[1] = 1'b0; bp_c[1] = 16'h4040;
        bp_a[2] = 16'h4040; bp_b[2] = 16'h3F80; bp_op[2] = 1'b1; bp_c[2] = 16'h4000;
        bp_a[3] = 16'hBF80; bp_b[3] = 16'hBF80; bp_op[3] = 1'b0; bp_c[3] = 16'hC000;
        bp_a[4] = 16'h3F80; bp_b[4] = 16'h3F00; bp_op[4] = 1'b0; bp_c[4] = 16'h3FC0;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                a = bp_a[sent]; b = bp_b[sent]; cntl = bp_op[sent];
            end
            #1;
            if (out_valid) begin
                check($sformatf("bp_c%0d", got), c, bp_c[got]);
                $display("txn bp idx=%0d c=%h ready=%0d", got, c, out_ready);
            end
            accepted  = in_valid && in_ready;
            delivered = out_valid && out_ready;
            @(posedge clk);
            if (accepted)  sent++;
            if (delivered) got++;
        end
        in_valid = 1'b0;
        check("bp_count", got, 5);
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_nodup%0d", k), out_valid, 0);
        end

        // Mid-stream reset: fill and stall, then reset between clock edges.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h3F80; b = 16'h3F80; cntl = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_async_valid", out_valid, 0);
        check("rst_mid_c", c, 16'h0000);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_mid_nostale%0d", k), out_valid, 0);
        end
        $display("txn rst_mid out_valid=%0d", out_valid);

        run_one("post_rst", 16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000);

        run_h("half_add",  16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        run_h("half_subn", 16'h0400, 16'h03FF, 1'b1, 16'h0400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
